rattlesnake_mem_responder: RTL and testbench
============================================

# rattlesnake_mem_responder

Memory-side responder for the Rattlesnake core's instruction-fetch read port and data load/store port. It accepts fetch read requests (`read_mem_enable`/`read_mem_addr`) and data-port requests, arbitrates them onto one single-port synchronous SRAM, and returns `mem_read_done`/`mem_data`/`mem_addr_ack` to the fetch unit. It sits between the core's fetch and load/store logic and the on-chip RAM macro.

## Interface
- `MEM_ADDR_BITS`, 14, word-address width of the SRAM
- `XLEN`, 32, data width
- `WAIT_STATES`, 0, extra SRAM read-latency cycles (0..3)
- `clk` in 1, core clock
- `reset` in 1, asynchronous, active-high reset
- `sync_reset` in 1, synchronous abort: clears pending requests, FSM to S_IDLE
- `read_mem_enable` in 1, fetch read request pulse
- `read_mem_addr` in 32, fetch byte address; word index = `[MEM_ADDR_BITS+1:2]`
- `mem_read_done` out 1, one-cycle fetch completion pulse
- `mem_data` out XLEN, fetched word, valid with `mem_read_done`
- `mem_addr_ack` out MEM_ADDR_BITS, word index of the returned fetch
- `dm_rd` / `dm_we` in 1 each, data read / write request pulses (mutually exclusive)
- `dm_addr` in 32, data byte address; `dm_wdata` in XLEN; `dm_byte_en` in 4
- `dm_done` out 1, one-cycle data completion pulse; `dm_rdata` out XLEN
- `sram_ce`, `sram_we` out 1; `sram_addr` out MEM_ADDR_BITS; `sram_din` out XLEN; `sram_be` out 4; `sram_dout` in XLEN

## Operation
- One pending slot per port. A fetch request loads the fetch slot, and a newer fetch request overwrites an unserved one (latest address wins). Data requests load the data slot.
- A request arriving while the FSM is in S_IDLE with no competing request issues directly without passing through the slot.
- Arbitration in S_IDLE: the data slot has priority over the fetch slot.
- FSM states:
  - S_IDLE: select a request and register the SRAM command.
  - S_ISSUE: `sram_ce`=1 for one cycle. A write goes to S_IDLE with `dm_done` registered. A read goes to S_WAIT.
  - S_WAIT: down-counter loaded with WAIT_STATES. At count 0, capture `sram_dout` into `mem_data` or `dm_rdata`, pulse the matching done, and go to S_IDLE.
- An in-flight fetch always completes with its own address on `mem_addr_ack`, even if a newer fetch has since been queued. The queued fetch is served next.
- A byte write drives `sram_be` = `dm_byte_en`. A read drives `sram_be` = 4'hF.
- Reset values: all outputs 0, both slots empty, counter 0, S_IDLE.
- `sync_reset` mid-access drops the access. No done pulse follows.

## Timing
- Fetch read, idle FSM, request in cycle 0:
  - `sram_ce` high in cycle 1.
  - `sram_dout` sampled at end of cycle 2+WAIT_STATES.
  - `mem_read_done` high in cycle 3+WAIT_STATES.
- Data write, request in cycle 0: `sram_we` high in cycle 1, `dm_done` high in cycle 2.
- The next command may be registered in the same cycle a done pulse is high.
- Read throughput is one access per 3+WAIT_STATES cycles.
- Simultaneous fetch and data request in cycle 0: the data access starts first. The fetch's `sram_ce` follows in the cycle after the data done pulse.
- `mem_read_done` and `dm_done` are never high in the same cycle.

## Configuration
- `RATTLESNAKE_FETCH_PRIORITY_EN`:
  - Defined: the fetch slot wins ties in S_IDLE.
  - Undefined (default): data wins, as described above.
- No other behaviour changes with this macro.

## Test plan
- `reset` pulse mid-S_WAIT -> every output 0 next cycle. `read_mem_enable` at addr 0x100 then gives `mem_addr_ack`=0x40 and `mem_read_done` 3 cycles later (WAIT_STATES=0).
- WAIT_STATES=2, fetch of 0x8 with SRAM word 0xDEADBEEF -> `mem_read_done` in cycle 5, `mem_data`=0xDEADBEEF, `mem_addr_ack`=2.
- Fetch 0x10 issued, then fetch 0x20 one cycle later -> done with ack 4, then done with ack 8. Neither is lost or duplicated.
- Fetch 0x0 and `dm_we` (addr 0x4, wdata 0x12345678, be 4'b0011) in the same cycle -> `dm_done` precedes `mem_read_done`. A later read of 0x4 returns the low halfword 0x5678 merged with the old upper bytes.
- Same stimulus with `RATTLESNAKE_FETCH_PRIORITY_EN` defined -> `mem_read_done` precedes `dm_done`.
- `sync_reset` in cycle 1 of a fetch -> no `mem_read_done`, FSM in S_IDLE. A new fetch is then accepted normally.

Source files
------------

// File: rtl/rattlesnake_mem_responder_if.sv
// Fetch, data-port and SRAM macro signals of the Rattlesnake memory responder.
// The slave modport is the responder's view; master is the core/SRAM side.
// Widths follow the responder's MEM_ADDR_BITS/XLEN parameters.
interface rattlesnake_mem_responder_if #(
    parameter int MEM_ADDR_BITS = 14,
    parameter int XLEN          = 32
);
    // instruction-fetch read port
    logic                     read_mem_enable;
    logic [31:0]              read_mem_addr;
    logic                     mem_read_done;
    logic [XLEN-1:0]          mem_data;
    logic [MEM_ADDR_BITS-1:0] mem_addr_ack;

    // data load/store port
    logic                     dm_rd;
    logic                     dm_we;
    logic [31:0]              dm_addr;
    logic [XLEN-1:0]          dm_wdata;
    logic [3:0]               dm_byte_en;
    logic                     dm_done;
    logic [XLEN-1:0]          dm_rdata;

    // single-port synchronous SRAM
    logic                     sram_ce;
    logic                     sram_we;
    logic [MEM_ADDR_BITS-1:0] sram_addr;
    logic [XLEN-1:0]          sram_din;
    logic [3:0]               sram_be;
    logic [XLEN-1:0]          sram_dout;

    modport slave (
        input  read_mem_enable, read_mem_addr,
        output mem_read_done, mem_data, mem_addr_ack,
        input  dm_rd, dm_we, dm_addr, dm_wdata, dm_byte_en,
        output dm_done, dm_rdata,
        output sram_ce, sram_we, sram_addr, sram_din, sram_be,
        input  sram_dout
    );

    modport master (
        output read_mem_enable, read_mem_addr,
        input  mem_read_done, mem_data, mem_addr_ack,
        output dm_rd, dm_we, dm_addr, dm_wdata, dm_byte_en,
        input  dm_done, dm_rdata,
        input  sram_ce, sram_we, sram_addr, sram_din, sram_be,
        output sram_dout
    );
endinterface

// File: rtl/rattlesnake_mem_responder.sv
// Arbitrates Rattlesnake fetch reads and data loads/stores onto one synchronous SRAM.
// Latency: read done 3+WAIT_STATES cycles after request, write done 2 cycles after request.
// No backpressure: one pending slot per port, a newer fetch overwrites an unserved one.
// Macro RATTLESNAKE_FETCH_PRIORITY_EN: when defined the fetch slot wins ties, else data wins.
module rattlesnake_mem_responder #(
    parameter int MEM_ADDR_BITS = 14,
    parameter int XLEN          = 32,
    parameter int WAIT_STATES   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sync_reset,
    rattlesnake_mem_responder_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_STATES);

    state_t                   state_q, state_d;
    logic [1:0]               cnt_q, cnt_d;

    // pending request slots
    logic                     f_pend_q, f_pend_d;
    logic [MEM_ADDR_BITS-1:0] f_addr_q, f_addr_d;
    logic                     d_pend_q, d_pend_d;
    logic                     d_we_q, d_we_d;
    logic [MEM_ADDR_BITS-1:0] d_addr_q, d_addr_d;
    logic [XLEN-1:0]          d_wdata_q, d_wdata_d;
    logic [3:0]               d_be_q, d_be_d;

    // in-flight access kind: 1 = data port, 0 = fetch
    logic                     op_data_q, op_data_d;

    // registered SRAM command
    logic                     sram_ce_q, sram_ce_d;
    logic                     sram_we_q, sram_we_d;
    logic [MEM_ADDR_BITS-1:0] sram_addr_q, sram_addr_d;
    logic [XLEN-1:0]          sram_din_q, sram_din_d;
    logic [3:0]               sram_be_q, sram_be_d;

    // registered responses
    logic                     rd_done_q, rd_done_d;
    logic [XLEN-1:0]          mem_data_q, mem_data_d;
    logic [MEM_ADDR_BITS-1:0] ack_q, ack_d;
    logic                     dm_done_q, dm_done_d;
    logic [XLEN-1:0]          dm_rdata_q, dm_rdata_d;

    // arbitration candidates: an incoming pulse supersedes the slot contents
    logic                     in_dm;
    logic                     f_avail, d_avail;
    logic [MEM_ADDR_BITS-1:0] in_f_idx, in_d_idx;
    logic [MEM_ADDR_BITS-1:0] eff_f_addr, eff_d_addr;
    logic                     eff_d_we;
    logic [XLEN-1:0]          eff_d_wdata;
    logic [3:0]               eff_d_be;
    logic                     pick_d, pick_f;

    assign in_dm       = bus.dm_rd | bus.dm_we;
    assign in_f_idx    = bus.read_mem_addr[MEM_ADDR_BITS+1:2];
    assign in_d_idx    = bus.dm_addr[MEM_ADDR_BITS+1:2];
    assign f_avail     = f_pend_q | bus.read_mem_enable;
    assign d_avail     = d_pend_q | in_dm;
    assign eff_f_addr  = bus.read_mem_enable ? in_f_idx : f_addr_q;
    assign eff_d_addr  = in_dm ? in_d_idx : d_addr_q;
    assign eff_d_we    = in_dm ? bus.dm_we : d_we_q;
    assign eff_d_wdata = in_dm ? bus.dm_wdata : d_wdata_q;
    assign eff_d_be    = in_dm ? bus.dm_byte_en : d_be_q;

    // byte-offset and high address bits are not decoded by this SRAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.read_mem_addr[31:MEM_ADDR_BITS+2], bus.read_mem_addr[1:0],
                                bus.dm_addr[31:MEM_ADDR_BITS+2], bus.dm_addr[1:0]};

    // next-state: slot capture, arbitration, SRAM sequencing and response generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f_pend_d    = f_pend_q;
        f_addr_d    = f_addr_q;
        d_pend_d    = d_pend_q;
        d_we_d      = d_we_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        d_be_d      = d_be_q;
        op_data_d   = op_data_q;
        sram_ce_d   = 1'b0;
        sram_we_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        sram_be_d   = sram_be_q;
        rd_done_d   = 1'b0;
        mem_data_d  = mem_data_q;
        ack_d       = ack_q;
        dm_done_d   = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        pick_d      = 1'b0;
        pick_f      = 1'b0;

        // latest request always lands in its slot; issuing clears it below
        if (bus.read_mem_enable) begin
            f_pend_d = 1'b1;
            f_addr_d = in_f_idx;
        end
        if (in_dm) begin
            d_pend_d  = 1'b1;
            d_we_d    = bus.dm_we;
            d_addr_d  = in_d_idx;
            d_wdata_d = bus.dm_wdata;
            d_be_d    = bus.dm_byte_en;
        end

`ifdef RATTLESNAKE_FETCH_PRIORITY_EN
        pick_f = f_avail;
        pick_d = d_avail & ~f_avail;
`else
        pick_d = d_avail;
        pick_f = f_avail & ~d_avail;
`endif

        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    d_pend_d    = 1'b0;
                    op_data_d   = 1'b1;
                    sram_ce_d   = 1'b1;
                    sram_we_d   = eff_d_we;
                    sram_addr_d = eff_d_addr;
                    sram_din_d  = eff_d_we ? eff_d_wdata : sram_din_q;
                    sram_be_d   = eff_d_we ? eff_d_be : 4'hF;
                    state_d     = S_ISSUE;
                end else if (pick_f) begin
                    f_pend_d    = 1'b0;
                    op_data_d   = 1'b0;
                    sram_ce_d   = 1'b1;
                    sram_we_d   = 1'b0;
                    sram_addr_d = eff_f_addr;
                    sram_be_d   = 4'hF;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sram_we_q) begin
                    dm_done_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                    if (op_data_q) begin
                        dm_done_d  = 1'b1;
                        dm_rdata_d = bus.sram_dout;
                    end else begin
                        rd_done_d  = 1'b1;
                        mem_data_d = bus.sram_dout;
                        // in-flight address, not the slot, so a queued fetch cannot alias it
                        ack_d      = sram_addr_q;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort: drop the in-flight access and both slots, no done pulse follows
        if (sync_reset) begin
            state_d   = S_IDLE;
            cnt_d     = 2'd0;
            f_pend_d  = 1'b0;
            d_pend_d  = 1'b0;
            sram_ce_d = 1'b0;
            sram_we_d = 1'b0;
            rd_done_d = 1'b0;
            dm_done_d = 1'b0;
        end
    end

    // state, slots, SRAM command and responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            f_pend_q    <= 1'b0;
            f_addr_q    <= '0;
            d_pend_q    <= 1'b0;
            d_we_q      <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_be_q      <= 4'h0;
            op_data_q   <= 1'b0;
            sram_ce_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            sram_be_q   <= 4'h0;
            rd_done_q   <= 1'b0;
            mem_data_q  <= '0;
            ack_q       <= '0;
            dm_done_q   <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_pend_q    <= f_pend_d;
            f_addr_q    <= f_addr_d;
            d_pend_q    <= d_pend_d;
            d_we_q      <= d_we_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_be_q      <= d_be_d;
            op_data_q   <= op_data_d;
            sram_ce_q   <= sram_ce_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            sram_be_q   <= sram_be_d;
            rd_done_q   <= rd_done_d;
            mem_data_q  <= mem_data_d;
            ack_q       <= ack_d;
            dm_done_q   <= dm_done_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign bus.mem_read_done = rd_done_q;
    assign bus.mem_data      = mem_data_q;
    assign bus.mem_addr_ack  = ack_q;
    assign bus.dm_done       = dm_done_q;
    assign bus.dm_rdata      = dm_rdata_q;
    assign bus.sram_ce       = sram_ce_q;
    assign bus.sram_we       = sram_we_q;
    assign bus.sram_addr     = sram_addr_q;
    assign bus.sram_din      = sram_din_q;
    assign bus.sram_be       = sram_be_q;

endmodule

// File: tb/tb_rattlesnake_mem_responder.sv
// Directed bench: one responder with WAIT_STATES=0 (a) and one with WAIT_STATES=2 (b),
// each attached to a byte-enabled synchronous SRAM model. Cycle 0 is the request cycle;
// outputs are sampled 1 time unit after each rising edge.
module tb_rattlesnake_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic sr0;
    logic sr2;

    rattlesnake_mem_responder_if #(.MEM_ADDR_BITS(14), .XLEN(32)) a ();
    rattlesnake_mem_responder_if #(.MEM_ADDR_BITS(14), .XLEN(32)) b ();

    rattlesnake_mem_responder #(.MEM_ADDR_BITS(14), .XLEN(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .sync_reset(sr0), .bus(a));
    rattlesnake_mem_responder #(.MEM_ADDR_BITS(14), .XLEN(32), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .sync_reset(sr2), .bus(b));

    logic [31:0] ram0 [0:16383];
    logic [31:0] ram2 [0:16383];

    always @(posedge clk) begin
        if (a.sram_ce) begin
            if (a.sram_we) begin
                for (int i = 0; i < 4; i++)
                    if (a.sram_be[i]) ram0[a.sram_addr][8*i +: 8] <= a.sram_din[8*i +: 8];
            end else begin
                a.sram_dout <= ram0[a.sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (b.sram_ce) begin
            if (b.sram_we) begin
                for (int j = 0; j < 4; j++)
                    if (b.sram_be[j]) ram2[b.sram_addr][8*j +: 8] <= b.sram_din[8*j +: 8];
            end else begin
                b.sram_dout <= ram2[b.sram_addr];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    // done-pulse event records per DUT: cycle, ack and data of the first few pulses
    int          f0n, d0n, f2n, d2n, both0, both2;
    int          f0c [4];
    int          f0a [4];
    logic [31:0] f0d [4];
    int          d0c [4];
    logic [31:0] d0d [4];
    int          f2c [4];
    int          f2a [4];
    logic [31:0] f2d [4];
    int          d2c [4];
    logic [31:0] d2d [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        f0n = 0; d0n = 0; f2n = 0; d2n = 0; both0 = 0; both2 = 0;
        for (int k = 0; k < 4; k++) begin
            f0c[k] = -1; f0a[k] = -1; f0d[k] = '0; d0c[k] = -1; d0d[k] = '0;
            f2c[k] = -1; f2a[k] = -1; f2d[k] = '0; d2c[k] = -1; d2d[k] = '0;
        end
    endtask

    task automatic samp(input int c);
        if (a.mem_read_done) begin
            if (f0n < 4) begin f0c[f0n] = c; f0a[f0n] = int'(a.mem_addr_ack); f0d[f0n] = a.mem_data; end
            f0n++;
        end
        if (a.dm_done) begin
            if (d0n < 4) begin d0c[d0n] = c; d0d[d0n] = a.dm_rdata; end
            d0n++;
        end
        if (b.mem_read_done) begin
            if (f2n < 4) begin f2c[f2n] = c; f2a[f2n] = int'(b.mem_addr_ack); f2d[f2n] = b.mem_data; end
            f2n++;
        end
        if (b.dm_done) begin
            if (d2n < 4) begin d2c[d2n] = c; d2d[d2n] = b.dm_rdata; end
            d2n++;
        end
        if (a.mem_read_done && a.dm_done) both0++;
        if (b.mem_read_done && b.dm_done) both2++;
    endtask

    task automatic run(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            tick();
            samp(c);
        end
    endtask

    task automatic idle_all();
        a.read_mem_enable = 1'b0; a.dm_rd = 1'b0; a.dm_we = 1'b0;
        b.read_mem_enable = 1'b0; b.dm_rd = 1'b0; b.dm_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sr0 = 1'b0; sr2 = 1'b0;
        a.read_mem_addr = '0; a.dm_addr = '0; a.dm_wdata = '0; a.dm_byte_en = '0;
        b.read_mem_addr = '0; b.dm_addr = '0; b.dm_wdata = '0; b.dm_byte_en = '0;
        idle_all();
        clr();
        repeat (3) tick();

        // reset state
        chk("rst_sram_ce",   {31'd0, a.sram_ce}, 32'd0);
        chk("rst_sram_we",   {31'd0, a.sram_we}, 32'd0);
        chk("rst_sram_addr", 32'(a.sram_addr), 32'd0);
        chk("rst_sram_be",   32'(a.sram_be), 32'd0);
        chk("rst_rd_done",   {31'd0, a.mem_read_done}, 32'd0);
        chk("rst_dm_done",   {31'd0, a.dm_done}, 32'd0);
        chk("rst_mem_data",  a.mem_data, 32'd0);
        chk("rst_ack",       32'(a.mem_addr_ack), 32'd0);
        chk("rst_b_ce",      {31'd0, b.sram_ce}, 32'd0);
        reset = 1'b0;
        tick();

        // full-word write to word 1: command in cycle 1, done in cycle 2
        clr();
        a.dm_we = 1'b1; a.dm_addr = 32'h4; a.dm_wdata = 32'hAABBCCDD; a.dm_byte_en = 4'hF;
        tick(); samp(1); idle_all();
        chk("wr_ce_c1",   {31'd0, a.sram_ce}, 32'd1);
        chk("wr_we_c1",   {31'd0, a.sram_we}, 32'd1);
        chk("wr_addr_c1", 32'(a.sram_addr), 32'd1);
        chk("wr_din_c1",  a.sram_din, 32'hAABBCCDD);
        run(2, 6);
        chk("wr_done_n",   32'(d0n), 32'd1);
        chk("wr_done_cyc", 32'(d0c[0]), 32'd2);

        // word 0 on a, word 2 on b (WAIT_STATES does not affect writes)
        clr();
        a.dm_we = 1'b1; a.dm_addr = 32'h0; a.dm_wdata = 32'h11112222; a.dm_byte_en = 4'hF;
        b.dm_we = 1'b1; b.dm_addr = 32'h8; b.dm_wdata = 32'hDEADBEEF; b.dm_byte_en = 4'hF;
        tick(); samp(1); idle_all();
        run(2, 6);
        chk("ws2_wr_done_cyc", 32'(d2c[0]), 32'd2);

        // single fetch on both DUTs
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h0;
        b.read_mem_enable = 1'b1; b.read_mem_addr = 32'h8;
        tick(); samp(1); idle_all();
        chk("rd_ce_c1", {31'd0, a.sram_ce}, 32'd1);
        chk("rd_we_c1", {31'd0, a.sram_we}, 32'd0);
        chk("rd_be_c1", 32'(a.sram_be), 32'hF);
        run(2, 10);
        chk("rd_n",        32'(f0n), 32'd1);
        chk("rd_cyc",      32'(f0c[0]), 32'd3);
        chk("rd_data",     f0d[0], 32'h11112222);
        chk("ws2_rd_n",    32'(f2n), 32'd1);
        chk("ws2_rd_cyc",  32'(f2c[0]), 32'd5);
        chk("ws2_rd_data", f2d[0], 32'hDEADBEEF);
        chk("ws2_rd_ack",  32'(f2a[0]), 32'd2);

        // back-to-back fetches: second is queued while the first is in flight
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h10;
        tick(); samp(1);
        a.read_mem_addr = 32'h20;
        tick(); samp(2); idle_all();
        run(3, 12);
        chk("b2b_n",    32'(f0n), 32'd2);
        chk("b2b_ack0", 32'(f0a[0]), 32'd4);
        chk("b2b_cyc0", 32'(f0c[0]), 32'd3);
        chk("b2b_ack1", 32'(f0a[1]), 32'd8);
        chk("b2b_cyc1", 32'(f0c[1]), 32'd6);

        // simultaneous fetch of word 0 and low-halfword write to word 1
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h0;
        a.dm_we = 1'b1; a.dm_addr = 32'h4; a.dm_wdata = 32'h12345678; a.dm_byte_en = 4'b0011;
        tick(); samp(1); idle_all();
        run(2, 12);
        chk("col_rd_n",  32'(f0n), 32'd1);
        chk("col_dm_n",  32'(d0n), 32'd1);
        chk("col_both",  32'(both0), 32'd0);
        chk("col_rd_data", f0d[0], 32'h11112222);
`ifdef RATTLESNAKE_FETCH_PRIORITY_EN
        chk("col_rd_cyc", 32'(f0c[0]), 32'd3);
        chk("col_dm_cyc", 32'(d0c[0]), 32'd5);
`else
        chk("col_dm_cyc", 32'(d0c[0]), 32'd2);
        chk("col_rd_cyc", 32'(f0c[0]), 32'd5);
`endif

        // data reads: merged word 1 on a, word 2 on b
        clr();
        a.dm_rd = 1'b1; a.dm_addr = 32'h4;
        b.dm_rd = 1'b1; b.dm_addr = 32'h8;
        tick(); samp(1); idle_all();
        run(2, 8);
        chk("dmrd_cyc",      32'(d0c[0]), 32'd3);
        chk("dmrd_data",     d0d[0], 32'hAABB5678);
        chk("ws2_dmrd_cyc",  32'(d2c[0]), 32'd5);
        chk("ws2_dmrd_data", d2d[0], 32'hDEADBEEF);

        // sync_reset during the issue cycle drops the fetch
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h30;
        tick(); samp(1); idle_all();
        sr0 = 1'b1;
        tick(); samp(2);
        sr0 = 1'b0;
        chk("sr_ce_c2", {31'd0, a.sram_ce}, 32'd0);
        run(3, 10);
        chk("sr_no_done", 32'(f0n), 32'd0);

        // normal fetch accepted after the abort
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h4;
        tick(); samp(1); idle_all();
        run(2, 8);
        chk("post_sr_cyc",  32'(f0c[0]), 32'd3);
        chk("post_sr_ack",  32'(f0a[0]), 32'd1);
        chk("post_sr_data", f0d[0], 32'hAABB5678);

        // asynchronous reset while the fetch sits in the wait state
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h4;
        tick(); samp(1); idle_all();
        tick(); samp(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ar_rd_done",  {31'd0, a.mem_read_done}, 32'd0);
        chk("ar_mem_data", a.mem_data, 32'd0);
        chk("ar_ack",      32'(a.mem_addr_ack), 32'd0);
        chk("ar_dm_rdata", a.dm_rdata, 32'd0);
        chk("ar_sram_addr", 32'(a.sram_addr), 32'd0);
        chk("ar_sram_be",  32'(a.sram_be), 32'd0);
        chk("ar_sram_ce",  {31'd0, a.sram_ce}, 32'd0);
        clr();
        run(4, 8);
        chk("ar_no_done", 32'(f0n), 32'd0);

        // fetch 0x100 after reset: word index 0x40
        clr();
        a.read_mem_enable = 1'b1; a.read_mem_addr = 32'h100;
        tick(); samp(1); idle_all();
        run(2, 8);
        chk("ar_fetch_n",   32'(f0n), 32'd1);
        chk("ar_fetch_cyc", 32'(f0c[0]), 32'd3);
        chk("ar_fetch_ack", 32'(f0a[0]), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
